// File: rtl/dispatch_stage.sv
// Dispatch stage: single-entry hold register between decode and the RS scheduler,
// plus the register-to-producer LUT that builds each instruction's dependency mask.
// Optional DISPATCH_STATS_EN adds saturating accept/stall counters.
module dispatch_stage #(
  parameter int NUM_FUS    = 4,
  parameter int RS_ENTRIES = 4,
  parameter int NUM_REGS   = 32,
  parameter int PKT_W      = 64,
  localparam int E     = RS_ENTRIES * NUM_FUS,
  localparam int IDX_W = $clog2(E),
  localparam int REG_W = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [PKT_W-1:0] dec_pkt,
  input  logic [REG_W-1:0] dec_rd,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic             dec_wr_rd,
  output logic             disp_valid,
  output logic [PKT_W-1:0] disp_pkt,
  output logic [E-1:0]     dependency_mask,
  input  logic             rs_full,
  input  logic [IDX_W-1:0] rs_entry_idx,
  input  logic             free_valid,
  input  logic [IDX_W-1:0] free_idx
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]      stat_disp_cnt,
  output logic [31:0]      stat_stall_cnt
`endif
);

  logic             valid_q, valid_d;
  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [E-1:0]     mask_q, mask_d;

  logic             busy_q [NUM_REGS];
  logic             busy_d [NUM_REGS];
  logic [IDX_W-1:0] prod_q [NUM_REGS];
  logic [IDX_W-1:0] prod_d [NUM_REGS];

  logic             accept, xfer, held, acc_wr;
  logic             byp1, byp2;
  logic [E-1:0]     new_mask;

  // Producer resolution for one source: accept bypass first, then the
  // same-cycle writeback suppresses the bit.
  function automatic logic [E-1:0] dep_of(
    input logic             use_s,
    input logic [REG_W-1:0] s,
    input logic             byp,
    input logic [IDX_W-1:0] byp_idx,
    input logic             lut_busy,
    input logic [IDX_W-1:0] lut_prod,
    input logic             fv,
    input logic [IDX_W-1:0] fidx
  );
    logic             b;
    logic [IDX_W-1:0] p;
    dep_of = '0;
    b = byp ? 1'b1 : lut_busy;
    p = byp ? byp_idx : lut_prod;
    if (use_s && (s != '0) && b && !(fv && (fidx == p)))
      dep_of[p] = 1'b1;
  endfunction

  always_comb begin
    accept    = valid_q && !rs_full;
    held      = valid_q && rs_full;
    dec_ready = !valid_q || accept;
    xfer      = dec_valid && dec_ready;
    acc_wr    = accept && wr_q && (rd_q != '0);
    byp1      = acc_wr && (rd_q == dec_rs1);
    byp2      = acc_wr && (rd_q == dec_rs2);
    new_mask  = dep_of(dec_use_rs1, dec_rs1, byp1, rs_entry_idx,
                       busy_q[dec_rs1], prod_q[dec_rs1], free_valid, free_idx)
              | dep_of(dec_use_rs2, dec_rs2, byp2, rs_entry_idx,
                       busy_q[dec_rs2], prod_q[dec_rs2], free_valid, free_idx);
  end

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      busy_d[r] = busy_q[r];
      prod_d[r] = prod_q[r];
      if (free_valid && busy_q[r] && (prod_q[r] == free_idx))
        busy_d[r] = 1'b0;
      if (acc_wr && (rd_q == REG_W'(r))) begin
        busy_d[r] = 1'b1;
        prod_d[r] = rs_entry_idx;
      end
      if (flush)
        busy_d[r] = 1'b0;
    end
  end

  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    mask_d  = mask_q;
    if (flush) begin
      valid_d = 1'b0;
      mask_d  = '0;
    end else if (xfer) begin
      valid_d = 1'b1;
      pkt_d   = dec_pkt;
      rd_d    = dec_rd;
      wr_d    = dec_wr_rd;
      mask_d  = new_mask;
    end else if (accept) begin
      valid_d = 1'b0;
      mask_d  = '0;
    end else if (held && free_valid) begin
      mask_d[free_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      mask_q  <= '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        busy_q[r] <= 1'b0;
        prod_q[r] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      mask_q  <= mask_d;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        busy_q[r] <= busy_d[r];
        prod_q[r] <= prod_d[r];
      end
    end
  end

  assign disp_valid      = valid_q;
  assign disp_pkt        = pkt_q;
  assign dependency_mask = mask_q;

`ifdef DISPATCH_STATS_EN
  logic [31:0] disp_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept && (disp_cnt_q != '1))
        disp_cnt_q <= disp_cnt_q + 32'd1;
      if (held && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_disp_cnt  = disp_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule
